// File: rtl/cmp_defs.sv
// Shared definitions for the comparator result tracker slice.
//   CMP_LT / CMP_GT / CMP_EQ : one-hot comparator result codes
//   S_WAIT / S_SETTLE / S_STABLE : tracker FSM state encodings (2 bits)
//   is_valid_code() : true when exactly one result bit is set
package cmp_defs;

  localparam logic [2:0] CMP_LT = 3'b001;
  localparam logic [2:0] CMP_GT = 3'b010;
  localparam logic [2:0] CMP_EQ = 3'b100;

  localparam logic [1:0] S_WAIT   = 2'd0;
  localparam logic [1:0] S_SETTLE = 2'd1;
  localparam logic [1:0] S_STABLE = 2'd2;

  function automatic logic is_valid_code(input logic [2:0] c);
    return (c == CMP_LT) || (c == CMP_GT) || (c == CMP_EQ);
  endfunction

endpackage

// File: rtl/cmp_result_tracker_if.sv
// Bundle between the result tracker and its user.
//   q_in, clr                  : raw comparator code and counter clear (user -> tracker)
//   res_q, res_valid,
//   change_pulse, cnt_*        : published result, strobe and event counters (tracker -> user)
//   err_cnt                    : invalid-code episode counter, only with CMP_ERR_CNT_EN
// Modports: master = user side, slave = tracker side.
interface cmp_result_tracker_if #(
  parameter int unsigned CNT_W = 8
);

  logic [2:0]       q_in;
  logic             clr;
  logic [2:0]       res_q;
  logic             res_valid;
  logic             change_pulse;
  logic [CNT_W-1:0] cnt_lt;
  logic [CNT_W-1:0] cnt_gt;
  logic [CNT_W-1:0] cnt_eq;
`ifdef CMP_ERR_CNT_EN
  logic [CNT_W-1:0] err_cnt;

  modport master (output q_in, clr,
                  input  res_q, res_valid, change_pulse, cnt_lt, cnt_gt, cnt_eq, err_cnt);
  modport slave  (input  q_in, clr,
                  output res_q, res_valid, change_pulse, cnt_lt, cnt_gt, cnt_eq, err_cnt);
`else
  modport master (output q_in, clr,
                  input  res_q, res_valid, change_pulse, cnt_lt, cnt_gt, cnt_eq);
  modport slave  (input  q_in, clr,
                  output res_q, res_valid, change_pulse, cnt_lt, cnt_gt, cnt_eq);
`endif

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous switch-derived inputs.
//   clk : destination clock
//   rst : asynchronous, active-high reset (outputs clear to 0)
//   d   : asynchronous input bus
//   q   : synchronised output, two clk edges behind d
module sync_2ff #(
  parameter int unsigned W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/cmp_result_tracker.sv
// Synchronises and debounces the 1-bit comparator's one-hot result, publishes
// a stable registered code with a change strobe and keeps saturating
// per-class event counters.
//   clk, rst : system clock, asynchronous active-high reset
//   bus      : slave side of cmp_result_tracker_if
//              (q_in, clr in; res_q, res_valid, change_pulse, cnt_lt/gt/eq out)
// Optional: define CMP_ERR_CNT_EN to add bus.err_cnt, counting invalid codes
// that stay stable for DEB_CYCLES.
module cmp_result_tracker
  import cmp_defs::*;
#(
  parameter int unsigned DEB_CYCLES = 16,
  parameter int unsigned CNT_W      = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  cmp_result_tracker_if.slave  bus
);

  localparam logic [15:0] DEB_MAX = 16'(DEB_CYCLES);
  localparam logic [15:0] DEB_M1  = 16'(DEB_CYCLES - 1);

  logic [2:0]  q_s;
  logic [2:0]  cand_q;
  logic [15:0] count_q;
  logic [1:0]  state_q, state_d;
  logic [2:0]  res_q;
  logic        res_valid_q;
  logic        pulse_q;
  logic [CNT_W-1:0] cnt_lt_q, cnt_gt_q, cnt_eq_q;

  logic changed;
  logic reach;
  logic cand_ok;
  logic accept;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  sync_2ff #(.W(3)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.q_in),
    .q   (q_s)
  );

  // reach is true only on the edge where the count steps onto DEB_CYCLES,
  // so each stable episode produces at most one decision. Gating on S_SETTLE
  // keeps the post-reset 000 (never a real change) from being judged.
  assign changed = (q_s != cand_q);
  assign reach   = !changed && (count_q == DEB_M1) && (state_q == S_SETTLE);
  assign cand_ok = is_valid_code(cand_q);
  assign accept  = reach && cand_ok && (cand_q != res_q);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_WAIT:   if (changed) state_d = S_SETTLE;
      S_SETTLE: if (!changed && reach && cand_ok) state_d = S_STABLE;
      S_STABLE: if (changed) state_d = S_SETTLE;
      default:  state_d = S_WAIT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cand_q      <= '0;
      count_q     <= '0;
      state_q     <= S_WAIT;
      res_q       <= '0;
      res_valid_q <= 1'b0;
      pulse_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      pulse_q <= accept;
      if (changed) begin
        cand_q  <= q_s;
        count_q <= '0;
      end else if (count_q != DEB_MAX) begin
        count_q <= count_q + 16'd1;
      end
      if (accept) begin
        res_q       <= cand_q;
        res_valid_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_lt_q <= '0;
      cnt_gt_q <= '0;
      cnt_eq_q <= '0;
    end else if (bus.clr) begin
      cnt_lt_q <= '0;
      cnt_gt_q <= '0;
      cnt_eq_q <= '0;
    end else if (accept) begin
      if (cand_q == CMP_LT) cnt_lt_q <= sat_inc(cnt_lt_q);
      if (cand_q == CMP_GT) cnt_gt_q <= sat_inc(cnt_gt_q);
      if (cand_q == CMP_EQ) cnt_eq_q <= sat_inc(cnt_eq_q);
    end
  end

`ifdef CMP_ERR_CNT_EN
  logic [CNT_W-1:0] err_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt_q <= '0;
    end else if (bus.clr) begin
      err_cnt_q <= '0;
    end else if (reach && !cand_ok) begin
      err_cnt_q <= sat_inc(err_cnt_q);
    end
  end

  assign bus.err_cnt = err_cnt_q;
`endif

  assign bus.res_q        = res_q;
  assign bus.res_valid    = res_valid_q;
  assign bus.change_pulse = pulse_q;
  assign bus.cnt_lt       = cnt_lt_q;
  assign bus.cnt_gt       = cnt_gt_q;
  assign bus.cnt_eq       = cnt_eq_q;

endmodule
